// File: rtl/alu_mul_sequencer_if.sv
// Request/result handshake and external Hack ALU bus of the multiply sequencer.
// master = CPU side (requests and hosts the ALU), slave = sequencer.
interface alu_mul_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             prod_zr;
  logic             prod_ng;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [5:0]       alu_ctl;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zr;
  logic             alu_ng;

  modport master (
    output start, a, b,
    input  busy, done, product, prod_zr, prod_ng,
    input  alu_x, alu_y, alu_ctl,
    output alu_out, alu_zr, alu_ng
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, prod_zr, prod_ng,
    output alu_x, alu_y, alu_ctl,
    input  alu_out, alu_zr, alu_ng
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier (low WIDTH bits) that performs every addition and
// doubling through the shared Hack ALU, one ALU operation per clock.
module alu_mul_sequencer #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input logic                clk,
  input logic                reset_n,
  alu_mul_sequencer_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [5:0] CTL_ADD  = 6'b000010;
  localparam logic [5:0] CTL_PASS = 6'b001100;
  localparam logic [5:0] CTL_ZERO = 6'b101010;

  typedef enum logic [2:0] {
    IDLE,
    TEST,
    ADD,
    DBL,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0]    bit_cnt;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] product_q;
  logic             prod_zr_q, prod_ng_q;
  logic [WIDTH-1:0] alu_x, alu_y;
  logic [5:0]       alu_ctl;

  always_comb begin
    state_nx = state;
    alu_x    = '0;
    alu_y    = '0;
    alu_ctl  = CTL_ZERO;
    case (state)
      IDLE: if (bus.start) state_nx = TEST;
      TEST: begin
        if ((EARLY_EXIT && (mplier == '0)) || (bit_cnt == CW'(WIDTH)))
          state_nx = DONE;
        else if (mplier[0])
          state_nx = ADD;
        else
          state_nx = DBL;
      end
      ADD: begin
        alu_x    = acc;
        alu_y    = mcand;
        alu_ctl  = CTL_ADD;
        state_nx = DBL;
      end
      DBL: begin
        alu_x    = mcand;
        alu_y    = mcand;
        alu_ctl  = CTL_ADD;
        state_nx = TEST;
      end
      DONE: begin
        alu_x    = acc;
        alu_ctl  = CTL_PASS;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // busy/done are flopped from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      bit_cnt   <= '0;
      product_q <= '0;
      prod_zr_q <= 1'b0;
      prod_ng_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != IDLE);
      done_q <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc     <= '0;
            mcand   <= bus.a;
            mplier  <= bus.b;
            bit_cnt <= '0;
          end
        end
        ADD: acc <= bus.alu_out;
        DBL: begin
          mcand   <= bus.alu_out;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
        DONE: begin
          product_q <= acc;
          prod_zr_q <= bus.alu_zr;
          prod_ng_q <= bus.alu_ng;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.prod_zr = prod_zr_q;
  assign bus.prod_ng = prod_ng_q;
  assign bus.alu_x   = alu_x;
  assign bus.alu_y   = alu_y;
  assign bus.alu_ctl = alu_ctl;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: Hack ALU model on the bus, scoreboard
// of expected product/flags/latency per request, one early-exit and one full-length DUT.
module tb_alu_mul_sequencer;

  typedef struct {
    logic [15:0] p;
    logic        zr;
    logic        ng;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_r;
  logic [15:0] a_r, b_r;
  bit          sel;          // 0 = EARLY_EXIT=1 DUT, 1 = EARLY_EXIT=0 DUT
  int          total  = 0;
  int          passed = 0;
  exp_t        sb[$];
  logic [15:0] last_p[2];

  always #5 clk = ~clk;

  alu_mul_sequencer_if #(.WIDTH(16)) bus_ee   ();
  alu_mul_sequencer_if #(.WIDTH(16)) bus_full ();

  alu_mul_sequencer #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .reset_n(reset_n), .bus(bus_ee)
  );
  alu_mul_sequencer #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .reset_n(reset_n), .bus(bus_full)
  );

  function automatic logic [17:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] x1, y1, o;
    x1 = c[5] ? 16'h0000 : x;
    x1 = c[4] ? ~x1 : x1;
    y1 = c[3] ? 16'h0000 : y;
    y1 = c[2] ? ~y1 : y1;
    o  = c[1] ? (x1 + y1) : (x1 & y1);
    o  = c[0] ? ~o : o;
    return {(o == 16'h0000), o[15], o};
  endfunction

  always_comb {bus_ee.alu_zr, bus_ee.alu_ng, bus_ee.alu_out} =
    hack_alu(bus_ee.alu_x, bus_ee.alu_y, bus_ee.alu_ctl);
  always_comb {bus_full.alu_zr, bus_full.alu_ng, bus_full.alu_out} =
    hack_alu(bus_full.alu_x, bus_full.alu_y, bus_full.alu_ctl);

  assign bus_ee.start   = start_r & ~sel;
  assign bus_full.start = start_r & sel;
  assign bus_ee.a       = a_r;
  assign bus_ee.b       = b_r;
  assign bus_full.a     = a_r;
  assign bus_full.b     = b_r;

  logic        m_busy, m_done, m_zr, m_ng;
  logic [15:0] m_prod;
  logic [5:0]  m_ctl;
  assign m_busy = sel ? bus_full.busy    : bus_ee.busy;
  assign m_done = sel ? bus_full.done    : bus_ee.done;
  assign m_prod = sel ? bus_full.product : bus_ee.product;
  assign m_zr   = sel ? bus_full.prod_zr : bus_ee.prod_zr;
  assign m_ng   = sel ? bus_full.prod_ng : bus_ee.prod_ng;
  assign m_ctl  = sel ? bus_full.alu_ctl : bus_ee.alu_ctl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] b, input bit full);
    int k = 0;
    int p = 0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        p++;
        k = i + 1;
      end
    end
    return full ? (2 + 32 + p) : (2 + 2 * k + p);
  endfunction

  function automatic bit legal_ctl(input logic [5:0] c);
    return (c == 6'b000010) || (c == 6'b001100) || (c == 6'b101010);
  endfunction

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int poke_cyc,
                       input bit poke_done, input string tag);
    exp_t e;
    int   cyc;
    bit   busy_ok, ctl_ok, hold_ok;
    e.p   = a * b;
    e.zr  = (e.p == 16'h0000);
    e.ng  = e.p[15];
    e.lat = exp_lat(b, sel);
    sb.push_back(e);
    a_r = a; b_r = b; start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    a_r = 16'($urandom); b_r = 16'($urandom);
    cyc = 1; busy_ok = 1'b1; ctl_ok = 1'b1; hold_ok = 1'b1;
    while (!m_done && cyc < 200) begin
      if (m_busy !== 1'b1) busy_ok = 1'b0;
      if (!legal_ctl(m_ctl)) ctl_ok = 1'b0;
      if (m_prod !== last_p[sel]) hold_ok = 1'b0;
      if (cyc == poke_cyc) begin
        start_r = 1'b1;
        a_r = 16'h0005; b_r = 16'h0009;
      end else begin
        start_r = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_r = 1'b0;
    e = sb.pop_front();
    check({tag, "_done"}, m_done, 1);
    check({tag, "_lat"}, cyc, e.lat);
    check({tag, "_busy"}, busy_ok & m_busy, 1);
    check({tag, "_ctl"}, ctl_ok & legal_ctl(m_ctl), 1);
    check({tag, "_hold"}, hold_ok & (m_prod === last_p[sel]), 1);
    if (poke_done) begin
      start_r = 1'b1;
      a_r = 16'h0007; b_r = 16'h0007;
    end
    @(posedge clk); #1;
    start_r = 1'b0;
    check({tag, "_prod"}, m_prod, e.p);
    check({tag, "_zr"}, m_zr, e.zr);
    check({tag, "_ng"}, m_ng, e.ng);
    check({tag, "_idle"}, {m_busy, m_done}, 0);
    if (poke_done) begin
      @(posedge clk); #1;
      check({tag, "_doneign"}, m_busy, 0);
    end
    last_p[sel] = e.p;
  endtask

  initial begin
    int  cyc;
    bit  no_done;
    reset_n = 1'b0; start_r = 1'b0; a_r = '0; b_r = '0; sel = 1'b0;
    last_p[0] = '0; last_p[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {m_busy, m_done, m_zr, m_ng, m_prod}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    do_op(16'd17,   16'd3,    0, 1'b0, "m17x3");
    do_op(16'h1234, 16'h0000, 0, 1'b0, "bzero");
    do_op(16'h0000, 16'hFFFF, 0, 1'b0, "azero");
    do_op(16'hFFFF, 16'hFFFF, 0, 1'b0, "ffxff");
    do_op(16'd256,  16'd256,  0, 1'b0, "wrap");
    do_op(16'd3,    16'hFFFB, 0, 1'b0, "neg");
    do_op(16'd100,  16'd7,    3, 1'b0, "pokebusy");
    do_op(16'd9,    16'd9,    0, 1'b1, "pokedone");
    do_op(16'd12,   16'd11,   0, 1'b0, "afterdone");
    for (int i = 0; i < 3; i++) do_op(16'($urandom), 16'($urandom), 0, 1'b0, "rand");

    // abort mid-operation at cycle 10
    a_r = 16'h1111; b_r = 16'hFFFF; start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_clear", {m_busy, m_done, m_zr, m_ng, m_prod}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    last_p[0] = '0; last_p[1] = '0;
    no_done = 1'b1;
    for (cyc = 0; cyc < 60; cyc++) begin
      if (m_done !== 1'b0 || m_busy !== 1'b0) no_done = 1'b0;
      @(posedge clk); #1;
    end
    check("abort_nodone", no_done, 1);
    do_op(16'd17, 16'd3, 0, 1'b0, "postrst");

    sel = 1'b1;
    @(posedge clk); #1;
    do_op(16'd17, 16'd3, 0, 1'b0, "full17x3");
    do_op(16'h0040, 16'h0000, 0, 1'b0, "fullbzero");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle 16x16 multiplier (low WIDTH bits of the product) that reaches the existing Hack ALU only through its x/y/control/out/zr/ng interface. Every addition and doubling goes through the ALU, one ALU operation per clock. Shifting and sequencing are done locally. It sits beside the CPU's ALU and runs a multiply-instruction extension while the CPU is stalled on busy.

Parameters:
WIDTH, 16, operand/product/ALU data width
EARLY_EXIT, 1, 1 = finish as soon as remaining multiplier is zero; 0 = always process all WIDTH bits

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  multiplicand, latched on accepted start
b  input  WIDTH  multiplier, latched on accepted start
busy  output  1  high from the cycle after accept through the DONE cycle
done  output  1  one-cycle pulse, high during the DONE state
product  output  WIDTH  a*b mod 2^WIDTH, valid from DONE, held until next accept
prod_zr  output  1  ALU zr of product, captured in DONE
prod_ng  output  1  ALU ng of product, captured in DONE
alu_x  output  WIDTH  ALU x operand
alu_y  output  WIDTH  ALU y operand
alu_ctl  output  6  {zx,nx,zy,ny,f,no}
alu_out  input  WIDTH  ALU result (combinational, same cycle)
alu_zr  input  1  ALU zero flag
alu_ng  input  1  ALU negative flag

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy=0, done=0, product=0, prod_zr=0, prod_ng=0; internal acc/mcand/mplier/bit_cnt=0. Reset mid-operation aborts with no done pulse.
- Registers: acc, mcand, mplier (WIDTH each), bit_cnt (log2(WIDTH)+1 bits).
- ALU codes driven: ADD x+y = 000010; PASS x = 001100; IDLE constant 0 = 101010 with alu_x=alu_y=0.
- IDLE: if start=1, latch acc=0, mcand=a, mplier=b, bit_cnt=0, and go to TEST. Otherwise stay.
- TEST: choose the next state:
  - DONE if (EARLY_EXIT and mplier==0) or bit_cnt==WIDTH;
  - else ADD if mplier[0]=1;
  - else DBL.
  - ALU idle code is driven.
- ADD: alu_x=acc, alu_y=mcand, ctl=ADD; acc<=alu_out; next DBL.
- DBL: alu_x=alu_y=mcand, ctl=ADD; mcand<=alu_out; mplier<=mplier>>1 (zero fill); bit_cnt+1; next TEST.
- DONE: alu_x=acc, ctl=PASS; product<=acc; prod_zr<=alu_zr; prod_ng<=alu_ng; done=1; next IDLE. The new product, prod_zr and prod_ng are visible from the cycle after DONE. Previous values are held until then.
- All arithmetic is modulo 2^WIDTH. Carry out of the ALU is discarded. Signed operands need no special handling, because the low half is identical.
- Latency, EARLY_EXIT=1: done is high in cycle 2+2k+p after the accepting edge.
  - k = index of highest set bit of b, plus 1 (0 if b=0).
  - p = popcount(b).
  - Minimum 2 (b=0); maximum 50 (b=0xFFFF).
- Latency, EARLY_EXIT=0: 2+2*WIDTH+p.
- start while busy is ignored; latched operands do not change. start in the DONE cycle is also ignored (state≠IDLE). Back-to-back requests therefore need one IDLE cycle.
- a and b may change freely after the accept edge.
- alu_ctl/alu_x/alu_y are combinational from state and registers. Outputs busy/done are registered state decodes (glitch-free).

Test Plan:
- Reset, then a=17, b=3, start one cycle → done in cycle 8 after accept; product=51 (0x0033), zr=0, ng=0; busy high cycles 1–8.
- a=0x1234, b=0 → done at cycle 2, product=0, prod_zr=1; a=0, b=0xFFFF → product=0, zr=1, done at cycle 50.
- a=0xFFFF, b=0xFFFF → product=0x0001, zr=0, ng=0, done at cycle 50. a=256, b=256 → product=0x0000, zr=1.
- a=3, b=0xFFFB (−5) → product=0xFFF1 (−15), ng=1; check that alu_ctl shows only 000010, 001100 and 101010 throughout.
- Pulse start again mid-operation with different a/b → ignored, original product delivered. Start during DONE cycle → ignored, a later start in IDLE is accepted.
- Assert reset_n=0 mid-operation (b=0xFFFF, cycle 10) → busy and outputs clear immediately, no done; the next request completes correctly. Repeat 17×3 with EARLY_EXIT=0 → done at cycle 2+32+2=36.
